// File: rtl/store_buffer_pkg.sv
// Store buffer shared types and constants.
// Entry layout and store-kind encodings used by the buffer and its match logic.
package store_buffer_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int SB_DEPTH = 4;
    localparam int SB_PTR_W = 2;

    localparam logic ST_WORD = 1'b0;
    localparam logic ST_BYTE = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              is_byte;
    } entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Core-side store/load handshake and data_mem port of the store buffer.
// slave = the buffer itself, master = whoever drives the core and memory side.
interface store_buffer_if
    import store_buffer_pkg::*;
#(
    parameter int PTR_W = SB_PTR_W
);

    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_byte;

    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_stall;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_word_we;
    logic              mem_byte_we;
    logic [DATA_W-1:0] mem_rdata;

    logic              empty;
    logic [PTR_W:0]    count;

    modport slave (
        input  st_valid, st_addr, st_data, st_byte,
        output st_ready,
        input  ld_valid, ld_addr,
        output ld_data, ld_stall,
        output mem_addr, mem_wdata, mem_word_we, mem_byte_we,
        input  mem_rdata,
        output empty, count
    );

    modport master (
        output st_valid, st_addr, st_data, st_byte,
        input  st_ready,
        output ld_valid, ld_addr,
        input  ld_data, ld_stall,
        input  mem_addr, mem_wdata, mem_word_we, mem_byte_we,
        output mem_rdata,
        input  empty, count
    );

endinterface

// File: rtl/store_buffer_match.sv
// Youngest-match scan over the pending store entries.
// Walks from head towards tail so the last hit seen is the newest store.
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = SB_PTR_W
) (
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0][ADDR_W-3:0] word,
    input  logic [DEPTH-1:0]             byte_flag,
    input  logic [PTR_W-1:0]             head,
    input  logic [ADDR_W-3:0]            ld_word,
    output logic                         hit,
    output logic                         is_byte,
    output logic [PTR_W-1:0]             idx
);

    logic [PTR_W-1:0] slot;

    // Later (younger) matches override earlier ones in the scan.
    always_comb begin
        hit     = 1'b0;
        is_byte = 1'b0;
        idx     = head;
        slot    = head;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head + PTR_W'(k);
            if (valid[slot] && (word[slot] == ld_word)) begin
                hit     = 1'b1;
                is_byte = byte_flag[slot];
                idx     = slot;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer in front of data_mem.
// Drains one store per cycle, lets loads take the port, forwards word hits.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = SB_PTR_W
) (
    input logic           clk,
    input logic           reset,
    store_buffer_if.slave sbi
);

    entry_t                       entries [DEPTH];
    logic [DEPTH-1:0]             valid_q;
    logic [PTR_W-1:0]             head_q;
    logic [PTR_W-1:0]             tail_q;
    logic [PTR_W:0]               count_q;

    logic [DEPTH-1:0][ADDR_W-3:0] m_word;
    logic [DEPTH-1:0]             m_byte;
    logic                         hit;
    logic                         hit_byte;
    logic [PTR_W-1:0]             hit_idx;

    logic                         push;
    logic                         drain;
    logic                         ld_own;
    logic                         ready;
    entry_t                       head_e;

    // Flatten the entry array into the vectors the match scan expects.
    always_comb begin
        m_word = '0;
        m_byte = '0;
        for (int i = 0; i < DEPTH; i++) begin
            m_word[i] = entries[i].addr[ADDR_W-1:2];
            m_byte[i] = entries[i].is_byte;
        end
    end

    sb_match #(
        .DEPTH(DEPTH),
        .PTR_W(PTR_W)
    ) u_match (
        .valid    (valid_q),
        .word     (m_word),
        .byte_flag(m_byte),
        .head     (head_q),
        .ld_word  (sbi.ld_addr[ADDR_W-1:2]),
        .hit      (hit),
        .is_byte  (hit_byte),
        .idx      (hit_idx)
    );

    // Port arbitration: a missing load owns the port, otherwise drain the head.
    always_comb begin
        head_e = entries[head_q];
        ready  = !reset && (count_q < (PTR_W+1)'(DEPTH));
        ld_own = sbi.ld_valid && !hit;
        drain  = !reset && !ld_own && (count_q != '0);
        push   = sbi.st_valid && ready;
    end

    // Drive the memory port and the load result.
    always_comb begin
        sbi.st_ready    = ready;
        sbi.mem_addr    = '0;
        sbi.mem_wdata   = '0;
        sbi.mem_word_we = 1'b0;
        sbi.mem_byte_we = 1'b0;
        sbi.ld_stall    = !reset && sbi.ld_valid && hit && hit_byte;
        sbi.ld_data     = sbi.mem_rdata;
        if (hit && !hit_byte) begin
            sbi.ld_data = entries[hit_idx].data;
        end
        if (ld_own) begin
            sbi.mem_addr = sbi.ld_addr;
        end else if (drain) begin
            sbi.mem_addr    = head_e.addr;
            sbi.mem_wdata   = head_e.data;
            sbi.mem_word_we = (head_e.is_byte != ST_BYTE);
            sbi.mem_byte_we = (head_e.is_byte == ST_BYTE);
        end
        sbi.empty = (count_q == '0);
        sbi.count = count_q;
    end

    // Entry payload storage; only the valid bits need clearing on reset.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail_q] <= '{
                addr:    sbi.st_addr,
                data:    sbi.st_data,
                is_byte: sbi.st_byte
            };
        end
    end

    // Pointers, valid bits and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            if (drain) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            count_q <= count_q + {{PTR_W{1'b0}}, push}
                               - {{PTR_W{1'b0}}, drain};
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer.
// Queue-based reference model plus a data_mem model on the memory port.
module tb_store_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          is_byte;
    } st_t;

    logic clk = 1'b0;
    logic reset;

    store_buffer_if #(.PTR_W(2)) sbi ();

    store_buffer #(
        .DEPTH(DEPTH),
        .PTR_W(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sbi  (sbi)
    );

    always #5 clk = ~clk;

    // data_mem: small window, combinational read, write on negedge.
    logic [31:0] dmem [256];
    logic [31:0] refmem [256];
    logic [31:0] snap [256];

    assign sbi.mem_rdata = dmem[sbi.mem_addr[9:2]];

    always @(negedge clk) begin
        if (sbi.mem_word_we) begin
            dmem[sbi.mem_addr[9:2]] <= sbi.mem_wdata;
        end else if (sbi.mem_byte_we) begin
            dmem[sbi.mem_addr[9:2]][8*sbi.mem_addr[1:0] +: 8] <= sbi.mem_wdata[7:0];
        end
    end

    st_t q[$];
    int checks = 0;
    int errors = 0;
    logic        obs_stall;
    logic [31:0] obs_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit sv, input logic [31:0] sa,
                        input logic [31:0] sd, input bit sb, input bit lv,
                        input logic [31:0] la);
        bit hit, hb, drain;
        logic [31:0] hd;
        int n;
        reset        = rst;
        sbi.st_valid = sv;
        sbi.st_addr  = sa;
        sbi.st_data  = sd;
        sbi.st_byte  = sb;
        sbi.ld_valid = lv;
        sbi.ld_addr  = la;
        #1;
        obs_stall = sbi.ld_stall;
        obs_data  = sbi.ld_data;
        n = q.size();
        if (rst) begin
            chk("rst_ready", 32'(sbi.st_ready), 0);
            chk("rst_wwe", 32'(sbi.mem_word_we), 0);
            chk("rst_bwe", 32'(sbi.mem_byte_we), 0);
            chk("rst_stall", 32'(sbi.ld_stall), 0);
            q.delete();
        end else begin
            chk("count", 32'(sbi.count), 32'(n));
            chk("empty", 32'(sbi.empty), 32'(n == 0));
            chk("st_ready", 32'(sbi.st_ready), 32'(n < DEPTH));
            hit = 0;
            hb  = 0;
            hd  = '0;
            for (int j = n - 1; j >= 0; j--) begin
                if (q[j].addr[31:2] == la[31:2]) begin
                    hit = 1;
                    hb  = q[j].is_byte;
                    hd  = q[j].data;
                    break;
                end
            end
            if (lv) begin
                chk("ld_stall", 32'(sbi.ld_stall), 32'(hit && hb));
                if (hit && !hb) chk("ld_fwd", sbi.ld_data, hd);
                else if (!hit) chk("ld_mem", sbi.ld_data, refmem[la[9:2]]);
            end else begin
                chk("ld_stall_idle", 32'(sbi.ld_stall), 0);
            end
            drain = !(lv && !hit) && (n > 0);
            if (lv && !hit) begin
                chk("ld_addr", sbi.mem_addr, la);
                chk("ld_wwe", 32'(sbi.mem_word_we), 0);
                chk("ld_bwe", 32'(sbi.mem_byte_we), 0);
            end else if (drain) begin
                chk("dr_addr", sbi.mem_addr, q[0].addr);
                chk("dr_wdata", sbi.mem_wdata, q[0].data);
                chk("dr_wwe", 32'(sbi.mem_word_we), 32'(!q[0].is_byte));
                chk("dr_bwe", 32'(sbi.mem_byte_we), 32'(q[0].is_byte));
            end else begin
                chk("idle_addr", sbi.mem_addr, 0);
                chk("idle_wwe", 32'(sbi.mem_word_we), 0);
                chk("idle_bwe", 32'(sbi.mem_byte_we), 0);
            end
            if (drain) begin
                if (q[0].is_byte)
                    refmem[q[0].addr[9:2]][8*q[0].addr[1:0] +: 8] = q[0].data[7:0];
                else
                    refmem[q[0].addr[9:2]] = q[0].data;
                void'(q.pop_front());
            end
            if (sv && n < DEPTH) q.push_back('{addr: sa, data: sd, is_byte: sb});
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] MISS = 32'h1000_0100;

    initial begin
        int stalls;
        int diffs;
        bit done;
        for (int i = 0; i < 256; i++) begin
            dmem[i]   = '0;
            refmem[i] = '0;
        end
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        // 1: single word store drains next cycle
        step(0, 1, 32'h1000_0000, 32'hCAFE_BABE, 0, 0, 0);
        chk("t1_wwe", 32'(sbi.mem_word_we), 1);
        chk("t1_addr", sbi.mem_addr, 32'h1000_0000);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t1_empty", 32'(sbi.empty), 1);
        chk("t1_mem", dmem[0], 32'hCAFE_BABE);

        // 2: a missing load holds the port while the buffer fills
        for (int i = 0; i < 4; i++)
            step(0, 1, 32'h1000_0020 + 32'(4 * i), 32'h100 + 32'(i), 0, 1, MISS);
        chk("t2_full", 32'(sbi.st_ready), 0);
        step(0, 1, 32'h1000_0040, 32'hDEAD_0000, 0, 1, MISS);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);
        chk("t2_cnt", 32'(sbi.count), 0);
        chk("t2_mem", dmem[11], 32'h103);

        // 3: youngest word store is forwarded while the older one drains
        step(0, 1, 32'h1000_0008, 32'h1111_1111, 0, 1, MISS);
        step(0, 1, 32'h1000_0008, 32'h2222_2222, 0, 1, MISS);
        step(0, 0, 0, 0, 0, 1, 32'h1000_000A);
        chk("t3_fwd", obs_data, 32'h2222_2222);
        chk("t3_stall", 32'(obs_stall), 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t3_mem", dmem[2], 32'h2222_2222);

        // 4: a byte-store hit stalls until it retires
        step(0, 1, 32'h1000_0010, 32'hAABB_CCDD, 0, 0, 0);
        step(0, 1, 32'h1000_0011, 32'h0000_0077, 1, 0, 0);
        stalls = 0;
        done   = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            step(0, 0, 0, 0, 0, 1, 32'h1000_0010);
            if (obs_stall) stalls++;
            else done = 1;
        end
        chk("t4_done", 32'(done), 1);
        chk("t4_stalled", 32'(stalls != 0), 1);
        chk("t4_data", obs_data, 32'hAABB_77DD);

        // 5: push and drain together at count 2, across a pointer wrap
        step(0, 1, 32'h1000_0030, 32'h5A5A_0001, 0, 0, 0);
        step(0, 1, 32'h1000_0034, 32'h5A5A_0002, 0, 1, MISS);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 32'h1000_0050 + 32'(4 * i), 32'h6000 + 32'(i), 0, 0, 0);
            chk("t5_cnt", 32'(sbi.count), 2);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // 6: reset discards pending stores without touching memory
        for (int i = 0; i < 3; i++)
            step(0, 1, 32'h1000_0060 + 32'(4 * i), 32'hBAD0 + 32'(i), 0, 1, MISS);
        for (int i = 0; i < 256; i++) snap[i] = dmem[i];
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            chk("t6_wwe", 32'(sbi.mem_word_we), 0);
        end
        diffs = 0;
        for (int i = 0; i < 256; i++) if (snap[i] !== dmem[i]) diffs++;
        chk("t6_mem", 32'(diffs), 0);
        for (int i = 0; i < 256; i++) refmem[i] = dmem[i];

        // random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 1) == 1,
                 32'h1000_0000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3)),
                 $urandom,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 1) == 1,
                 32'h1000_0000 + 32'($urandom_range(0, 8) << 2) + 32'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0);
        diffs = 0;
        for (int i = 0; i < 256; i++) if (refmem[i] !== dmem[i]) diffs++;
        chk("final_mem", 32'(diffs), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
